// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect/halt control, instruction-memory port and
// the valid/ready instruction stream towards decode.
//   master : fetch_unit side (drives mem_addr, inst_valid, inst, inst_pc)
//   slave  : environment side (drives halt, redirect_*, mem_inst, inst_ready)
interface fetch_unit_if;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] mem_addr;
  logic [15:0] mem_inst;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  halt, redirect_valid, redirect_pc, mem_inst, inst_ready,
    output mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output halt, redirect_valid, redirect_pc, mem_inst, inst_ready,
    input  mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 16-bit CPU.
// Owns the PC, presents the fetch address to instruction memory, captures the
// returned word one cycle later and queues {inst, pc} pairs in a small FIFO
// that decode drains through a valid/ready handshake. A redirect flushes the
// FIFO, drops the in-flight fetch and restarts at the target.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fetch_unit_if.master (halt, redirect, memory port, inst stream)
// Parameters:
//   RESET_PC : PC loaded on reset
//   DEPTH    : FIFO entries (power of two, >= 2)
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   r_pc;
  logic          r_req;
  logic [15:0]   r_req_pc;
  logic [15:0]   r_buf_inst [DEPTH];
  logic [15:0]   r_buf_pc   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic [15:0]   w_addr;
  logic          w_deq;
  logic          w_push;
  logic          w_issue;
  logic [AW+1:0] w_occ;

  assign w_addr         = bus.redirect_valid ? bus.redirect_pc : r_pc;
  assign bus.mem_addr   = w_addr;
  assign bus.inst_valid = (r_count != '0);
  assign bus.inst       = r_buf_inst[r_rd_ptr];
  assign bus.inst_pc    = r_buf_pc[r_rd_ptr];

  assign w_deq  = bus.inst_valid & bus.inst_ready;
  assign w_push = r_req & ~bus.redirect_valid;

  // Projected occupancy after this cycle: queued + in flight - leaving now.
  // Never underflows because a dequeue implies count >= 1.
  assign w_occ   = {1'b0, r_count} + {{(AW+1){1'b0}}, r_req} - {{(AW+1){1'b0}}, w_deq};
  assign w_issue = ~bus.halt & (bus.redirect_valid | (w_occ < (AW+2)'(DEPTH)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_req_pc   <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_buf_inst <= '{default: '0};
      r_buf_pc   <= '{default: '0};
    end else begin
      r_req <= w_issue;
      if (w_issue) begin
        r_req_pc <= w_addr;
        r_pc     <= w_addr + 16'd1;
      end else if (bus.redirect_valid) begin
        r_pc <= bus.redirect_pc;
      end

      if (bus.redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_buf_inst[r_wr_ptr] <= bus.mem_inst;
          r_buf_pc[r_wr_ptr]   <= r_req_pc;
          r_wr_ptr             <= r_wr_ptr + AW'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_deq})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule
